fifo_rd_packer: RTL and testbench

Read-side consumer for `sync_fifo`. It drains DATA_WIDTH-bit entries through the FIFO's `rd_en`/`empty` interface and packs PACK_RATIO consecutive entries into one wide word. The word is presented on a valid/ready output port for the downstream bus interface. Partial words are emitted on an explicit flush or after an idle timeout, with a lane-keep mask.

---
 rtl/fifo_rd_packer.sv | 161 ++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Drains DATA_WIDTH-bit entries from a sync_fifo read port and packs
// PACK_RATIO consecutive entries into one wide word on a valid/ready output.
// Partial words go out on an explicit flush or after TIMEOUT idle cycles,
// with out_keep marking the populated low lanes.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO read strobe (combinational)
//   fifo_data   : FIFO read data, valid the cycle after fifo_rd_en
//   flush       : single-cycle request to emit the current partial word
//   out_valid   : output word valid
//   out_ready   : downstream accept
//   out_data    : packed word, lane 0 (first entry) in the low bits
//   out_keep    : per-lane valid mask
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep
);

  localparam int unsigned OW = DATA_WIDTH * PACK_RATIO;
  localparam int unsigned CW = $clog2(PACK_RATIO + 1);
  localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK_RATIO);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  flush_req_q, flush_req_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [OW-1:0]         acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [OW-1:0]         out_data_q, out_data_d;
  logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;

  logic                  rd_en;
  logic                  out_free;
  logic [CW-1:0]         cnt_cap;
  logic [OW-1:0]         acc_w;
  logic [OW-1:0]         part_word;
  logic [PACK_RATIO-1:0] part_keep;
  logic                  full_load;
  logic                  part_load;
  logic                  timeout_hit;
  logic                  flush_set;

  always_comb begin
    // Never issue a read that could overflow the accumulator, counting the
    // one already in flight; this is what costs one bubble per word.
    rd_en    = rst_n && !fifo_empty && !flush_req_q && ((cnt_q + CW'(pend_q)) < CNT_FULL);
    out_free = !out_valid_q || out_ready;
    cnt_cap  = cnt_q + CW'(pend_q);

    // Accumulator with this cycle's capture merged in, so a completing
    // word can be loaded in the same cycle its last lane arrives.
    acc_w     = acc_q;
    part_word = '0;
    part_keep = '0;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (pend_q && (cnt_q == CW'(i))) begin
        acc_w[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
      if (CW'(i) < cnt_q) begin
        part_word[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
        part_keep[i] = 1'b1;
      end
    end

    // cnt_cap == full covers both the completing capture and a word held
    // back by backpressure; the two load types are mutually exclusive.
    full_load = (cnt_cap == CNT_FULL) && out_free;
    part_load = flush_req_q && !pend_q && (cnt_q != '0) && (cnt_q != CNT_FULL) && out_free;

    cnt_d       = cnt_cap;
    pend_d      = rd_en;
    acc_d       = acc_w;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_keep_d  = '0;
    end

    if (full_load) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_w;
      out_keep_d  = '1;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (part_load) begin
      out_valid_d = 1'b1;
      out_data_d  = part_word;
      out_keep_d  = part_keep;
      cnt_d       = '0;
      acc_d       = '0;
    end

    // Idle counter saturates at TIMEOUT so a stalled partial word cannot
    // wrap it around.
    idle_d = idle_q;
    if (pend_q || full_load || part_load || (cnt_q == '0)) begin
      idle_d = '0;
    end else if (!rd_en && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + IW'(1);
    end

    timeout_hit = (TIMEOUT != 0) && (idle_q == IDLE_MAX) && (cnt_q != '0);
    flush_set   = (flush && ((cnt_q != '0) || pend_q)) || timeout_hit;

    // A pending flush is finished once nothing is left to emit; this also
    // drops a flush that raced a full-word completion without an empty word.
    flush_req_d = flush_req_q || flush_set;
    if ((cnt_d == '0) && !pend_d) begin
      flush_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      idle_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      flush_req_q <= flush_req_d;
      idle_q      <= idle_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a small FIFO model feeds the DUT, expected
// words are queued when bytes are pushed and compared by an output monitor
// on every accepted handshake.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PR = 4;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW*PR-1:0] out_data;
  logic [PR-1:0]   out_keep;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;
  word_t sb[$];

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    sb.push_back({d, k});
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Inputs change 1 time unit after posedge, so mid-cycle values are the
  // ones the next posedge will act on.
  always @(negedge clk) begin
    word_t w;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_word: observed data 0x%0h keep 0x%0h expected no word", out_data, out_keep);
      end
      if (sb.size() != 0) begin
        w = sb.pop_front();
        chk("word_data", out_data, w.data);
        chk("word_keep", 32'(out_keep), 32'(w.keep));
      end
    end
  end

  initial begin
    logic [8:0] pat;
    int n, last_rd, valid_at, reads;

    // Reset with a non-empty FIFO.
    for (int i = 1; i <= 8; i++) begin
      push_byte(8'(i * 17));
    end
    expect_word(32'h44332211, 4'hF);
    expect_word(32'h88776655, 4'hF);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_keep", 32'(out_keep), 32'd0);

    // Streaming.
    @(posedge clk); #1 rst_n = 1'b1;
    pat = '0;
    for (int i = 8; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = fifo_rd_en;
    end
    chk("stream_rd_pattern", 32'(pat), 32'(9'b1111_0_1111));
    drain("stream_drain", 20);

    // Backpressure.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push_byte(8'(i * 17));
    end
    expect_word(32'h44332211, 4'hF);
    expect_word(32'h88776655, 4'hF);
    repeat (14) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, 32'h44332211);
      chk("bp_rd_blocked", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
    end
    chk("bp_acc_full", 32'(dut.cnt_q), 32'd4);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_swap_valid", 32'(out_valid), 32'd1);
    chk("bp_swap_data", out_data, 32'h88776655);
    @(posedge clk); #1 out_ready = 1'b1;
    drain("bp_drain", 10);

    // Timeout. Last read strobe in cycle X is captured at the end of X+1;
    // the word registers TIMEOUT+2 edges later, so it is first seen at the
    // negedge of cycle X+TIMEOUT+4.
    @(posedge clk); #1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    expect_word(32'h0000A2A1, 4'h3);
    n = 0; last_rd = -1; valid_at = -1;
    while (valid_at < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en) last_rd = n;
      if (out_valid) valid_at = n;
    end
    chk("timeout_latency", 32'(valid_at - last_rd), 32'(TO + 4));
    drain("timeout_drain", 5);

    // Flush coinciding with the third read strobe.
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
    end
    expect_word(32'h00030201, 4'h7);
    expect_word(32'h00000004, 4'h1);
    n = 0; reads = 0;
    while (reads < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en) reads++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0; reads = 0;
    while (!out_valid && n < 20) begin
      if (fifo_rd_en) reads++;
      @(negedge clk);
      n++;
    end
    chk("flush_no_reads", 32'(reads), 32'd0);
    chk("flush_valid_seen", 32'(out_valid), 32'd1);
    drain("flush_drain", 60);

    // Reset mid-word.
    @(posedge clk); #1;
    push_byte(8'h01);
    push_byte(8'h02);
    n = 0; reads = 0;
    while (reads < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (fifo_rd_en) reads++;
    end
    repeat (2) @(negedge clk);
    chk("midreset_captured", 32'(dut.cnt_q), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_cnt", 32'(dut.cnt_q), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'(8'h55 + i));
    end
    expect_word(32'h58575655, 4'hF);
    drain("midreset_drain", 20);
    repeat (30) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
